// File: rtl/controle_reabastecimento_pkg.sv
// Shared encodings, widths and default constants for the cork refill scheduler
// and its BCD display helper.
package controle_reabastecimento_pkg;

  localparam int CNT_W   = 7;
  localparam int BCD_W   = 4;
  localparam int CNT_MAX = 99;

  localparam int TRAY_INIT_DEF   = 20;
  localparam int LOW_LEVEL_DEF   = 5;
  localparam int STOCK_INIT_DEF  = 60;
  localparam int REFILL_QTY_DEF  = 20;
  localparam int ACK_TIMEOUT_DEF = 4095;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_XFER      = 3'd2,
    ST_FAULT     = 3'd3,
    ST_EXHAUSTED = 3'd4
  } estado_t;

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/bin_para_bcd.sv
// Combinational 7-bit binary to two BCD digits (double-dabble).
// Inputs are expected to stay at or below 99; the hundreds carry is dropped.
module bin_para_bcd
  import controle_reabastecimento_pkg::*;
(
  input  logic [CNT_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_tens,
  output logic [BCD_W-1:0] o_units
);

  logic [BCD_W-1:0] w_tens;
  logic [BCD_W-1:0] w_units;

  always_comb begin
    w_tens  = '0;
    w_units = '0;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      if (w_tens >= 4'd5)  w_tens  = w_tens + 4'd3;
      if (w_units >= 4'd5) w_units = w_units + 4'd3;
      w_tens  = {w_tens[2:0], w_units[3]};
      w_units = {w_units[2:0], i_bin[i]};
    end
  end

  assign o_tens  = w_tens;
  assign o_units = w_units;

endmodule

// File: rtl/controle_reabastecimento.sv
// Cork supply refill scheduler: tracks tray and dispenser stock, runs the
// req/ack refill handshake and holds production when supply is exhausted.
//
// state      | meaning
// IDLE       | counting bottles, watching for low tray
// REQ        | disp_req high, ack timeout running
// XFER       | apply one refill, wait for ack to drop
// FAULT      | dispenser never acked; alarm + hold until reset/disable
// EXHAUSTED  | tray empty and no stock left; alarm until reset/disable
module controle_reabastecimento
  import controle_reabastecimento_pkg::*;
#(
  parameter int TRAY_INIT   = TRAY_INIT_DEF,
  parameter int STOCK_INIT  = STOCK_INIT_DEF,
  parameter int REFILL_QTY  = REFILL_QTY_DEF,
  parameter int LOW_LEVEL   = LOW_LEVEL_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_gp,
  input  logic             i_disp_ack,
  output logic             o_disp_req,
  output logic             o_hold_prod,
  output logic             o_alarm,
  output logic             o_cr,
  output logic             o_bz,
  output logic [BCD_W-1:0] o_tray_units,
  output logic [BCD_W-1:0] o_tray_tens,
  output logic             o_stock_empty
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] C_TRAY_INIT  = CNT_W'(TRAY_INIT);
  localparam logic [CNT_W-1:0] C_STOCK_INIT = CNT_W'(STOCK_INIT);
  localparam logic [CNT_W-1:0] C_REFILL     = CNT_W'(REFILL_QTY);
  localparam logic [CNT_W-1:0] C_LOW        = CNT_W'(LOW_LEVEL);
  localparam logic [CNT_W-1:0] C_MAX        = CNT_W'(CNT_MAX);
  localparam logic [CNT_W:0]   C_MAX_EXT    = (CNT_W + 1)'(CNT_MAX);
  // Loaded with one less so REQ lasts exactly ACK_TIMEOUT cycles.
  localparam logic [TMR_W-1:0] C_TMR_LOAD   = TMR_W'(ACK_TIMEOUT - 1);

  estado_t          r_state;
  logic [CNT_W-1:0] r_tray;
  logic [CNT_W-1:0] r_stock;
  logic [TMR_W-1:0] r_timer;
  logic             r_xfer_done;
  logic             r_disp_req;
  logic             r_alarm;

  logic             w_cr;
  logic             w_bz;
  logic             w_stock_empty;
  logic [CNT_W-1:0] w_tray_dec;
  logic [CNT_W-1:0] w_q;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_tray_fill;

  assign w_cr          = (r_tray <= C_LOW);
  assign w_bz          = (r_tray == '0);
  assign w_stock_empty = (r_stock == '0);

  assign w_tray_dec  = (i_gp && !w_bz) ? (r_tray - CNT_W'(1)) : r_tray;
  assign w_q         = min_cnt(C_REFILL, r_stock);
  assign w_sum       = {1'b0, w_tray_dec} + {1'b0, w_q};
  assign w_tray_fill = (w_sum > C_MAX_EXT) ? C_MAX : w_sum[CNT_W-1:0];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_tray      <= C_TRAY_INIT;
      r_stock     <= C_STOCK_INIT;
      r_timer     <= '0;
      r_xfer_done <= 1'b0;
      r_disp_req  <= 1'b0;
      r_alarm     <= 1'b0;
    end else if (!i_enable) begin
      r_state     <= ST_IDLE;
      r_tray      <= C_TRAY_INIT;
      r_stock     <= C_STOCK_INIT;
      r_timer     <= '0;
      r_xfer_done <= 1'b0;
      r_disp_req  <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_tray <= w_tray_dec;
      case (r_state)
        ST_IDLE: begin
          if (w_cr && !w_stock_empty) begin
            r_state    <= ST_REQ;
            r_disp_req <= 1'b1;
            r_timer    <= C_TMR_LOAD;
          end else if (w_bz && w_stock_empty) begin
            r_state <= ST_EXHAUSTED;
            r_alarm <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_disp_ack) begin
            r_state     <= ST_XFER;
            r_disp_req  <= 1'b0;
            r_xfer_done <= 1'b0;
          end else if (r_timer == '0) begin
            r_state    <= ST_FAULT;
            r_disp_req <= 1'b0;
            r_alarm    <= 1'b1;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        ST_XFER: begin
          // Refill lands once, net with any bottle sealed on the same edge.
          if (!r_xfer_done) begin
            r_tray      <= w_tray_fill;
            r_stock     <= r_stock - w_q;
            r_xfer_done <= 1'b1;
          end
          if (!i_disp_ack) r_state <= ST_IDLE;
        end
        ST_FAULT, ST_EXHAUSTED: begin
          r_disp_req <= 1'b0;
          r_alarm    <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_disp_req <= 1'b0;
        end
      endcase
    end
  end

  bin_para_bcd u_bcd (
    .i_bin  (r_tray),
    .o_tens (o_tray_tens),
    .o_units(o_tray_units)
  );

  assign o_disp_req    = r_disp_req;
  assign o_alarm       = r_alarm;
  assign o_cr          = w_cr;
  assign o_bz          = w_bz;
  assign o_stock_empty = w_stock_empty;
  assign o_hold_prod   = w_bz || (r_state == ST_FAULT);

endmodule

// File: tb/tb_controle_reabastecimento.sv
// Directed bench for the cork refill scheduler: vector table for the refill
// handshake plus hand sequences for timeout, exhaustion and async reset.
module tb_controle_reabastecimento;

  logic clk = 1'b0;
  logic rst_n, en, gp, ack;

  logic       req_a, hold_a, alarm_a, cr_a, bz_a, se_a;
  logic [3:0] tens_a, units_a;
  logic       req_b, hold_b, alarm_b, cr_b, bz_b, se_b;
  logic [3:0] tens_b, units_b;

  always #5 clk = ~clk;

  controle_reabastecimento dut (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_gp(gp), .i_disp_ack(ack),
    .o_disp_req(req_a), .o_hold_prod(hold_a), .o_alarm(alarm_a), .o_cr(cr_a),
    .o_bz(bz_a), .o_tray_units(units_a), .o_tray_tens(tens_a), .o_stock_empty(se_a)
  );

  controle_reabastecimento #(.STOCK_INIT(10)) dut_s10 (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_gp(gp), .i_disp_ack(ack),
    .o_disp_req(req_b), .o_hold_prod(hold_b), .o_alarm(alarm_b), .o_cr(cr_b),
    .o_bz(bz_b), .o_tray_units(units_b), .o_tray_tens(tens_b), .o_stock_empty(se_b)
  );

  wire [13:0] obs_a = {req_a, hold_a, alarm_a, cr_a, bz_a, se_a, tens_a, units_a};
  wire [13:0] obs_b = {req_b, hold_b, alarm_b, cr_b, bz_b, se_b, tens_b, units_b};

  int n_vec = 0;
  int n_err = 0;

  // {req, hold, alarm, cr, bz, stock_empty, tens, units}
  function automatic logic [13:0] pk(input logic req, input logic hold,
                                     input logic alarm, input logic cr,
                                     input logic bz, input logic se,
                                     input int t, input int u);
    return {req, hold, alarm, cr, bz, se, 4'(t), 4'(u)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic g, input logic a);
    @(negedge clk);
    gp  = g;
    ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic en_pulse();
    @(negedge clk);
    en  = 1'b0;
    gp  = 1'b0;
    ack = 1'b0;
    @(posedge clk);
    #1;
    chk("disable_outputs", obs_a, pk(0, 0, 0, 0, 0, 0, 2, 0));
    chk("disable_stock", dut.r_stock, 60);
    @(negedge clk);
    en = 1'b1;
  endtask

  typedef struct {
    logic        gp;
    logic        ack;
    logic [13:0] exp;
    int          stock;
    logic        chk_b;
    logic [13:0] exp_b;
  } vec_t;

  vec_t vt[9];
  int   n_req;

  initial begin
    // rows 0-4: refill with a 3-cycle ack; dut_s10 does its q=10 refill here
    vt[0] = '{0, 0, pk(1,0,0,1,0,0,0,5), 60, 1, pk(1,0,0,1,0,0,0,5)};
    vt[1] = '{0, 1, pk(0,0,0,1,0,0,0,5), 60, 0, '0};
    vt[2] = '{0, 1, pk(0,0,0,0,0,0,2,5), 40, 1, pk(0,0,0,0,0,1,1,5)};
    vt[3] = '{0, 1, pk(0,0,0,0,0,0,2,5), 40, 0, '0};
    vt[4] = '{0, 0, pk(0,0,0,0,0,0,2,5), 40, 0, '0};
    // rows 5-8: bottle sealed in the XFER cycle at tray=5
    vt[5] = '{0, 0, pk(1,0,0,1,0,0,0,5), 40, 0, '0};
    vt[6] = '{0, 1, pk(0,0,0,1,0,0,0,5), 40, 0, '0};
    vt[7] = '{1, 0, pk(0,0,0,0,0,0,2,4), 20, 0, '0};
    vt[8] = '{0, 0, pk(0,0,0,0,0,0,2,4), 20, 0, '0};

    rst_n = 1'b0;
    en    = 1'b1;
    gp    = 1'b0;
    ack   = 1'b0;
    #12;
    chk("reset_state", obs_a, pk(0, 0, 0, 0, 0, 0, 2, 0));
    chk("reset_state_s10", obs_b, pk(0, 0, 0, 0, 0, 0, 2, 0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= 15; k++) begin
      cyc(1'b1, 1'b0);
      chk("drain_20_to_5", obs_a, pk(0, 0, 0, (20 - k) <= 5, 0, 0, (20 - k) / 10, (20 - k) % 10));
    end

    for (int i = 0; i < 5; i++) begin
      cyc(vt[i].gp, vt[i].ack);
      chk($sformatf("vec%0d", i), obs_a, vt[i].exp);
      chk($sformatf("vec%0d_stock", i), dut.r_stock, vt[i].stock);
      if (vt[i].chk_b) chk($sformatf("vec%0d_s10", i), obs_b, vt[i].exp_b);
    end

    // 20 bottles: main tray 25->5; dut_s10 tray 15->0 and must never request
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0);
      chk("s10_no_req_when_stock_empty", req_b, 0);
    end
    chk("drain_25_to_5", obs_a, pk(0, 0, 0, 1, 0, 0, 0, 5));
    chk("s10_exhausted", obs_b, pk(0, 1, 1, 1, 1, 1, 0, 0));

    for (int i = 5; i < 9; i++) begin
      cyc(vt[i].gp, vt[i].ack);
      chk($sformatf("vec%0d", i), obs_a, vt[i].exp);
      chk($sformatf("vec%0d_stock", i), dut.r_stock, vt[i].stock);
    end

    // gp keeps consuming during REQ, tray reaches 0, refill still lands
    for (int i = 0; i < 19; i++) cyc(1'b1, 1'b0);
    chk("pre_req_tray5", obs_a, pk(0, 0, 0, 1, 0, 0, 0, 5));
    cyc(1'b1, 1'b0);
    chk("req_with_gp", obs_a, pk(1, 0, 0, 1, 0, 0, 0, 4));
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    chk("req_tray_empty_hold", obs_a, pk(1, 1, 0, 1, 1, 0, 0, 0));
    cyc(1'b1, 1'b0);
    chk("gp_at_zero_ignored", obs_a, pk(1, 1, 0, 1, 1, 0, 0, 0));
    cyc(1'b0, 1'b1);
    chk("xfer_from_zero", obs_a, pk(0, 1, 0, 1, 1, 0, 0, 0));
    cyc(1'b0, 1'b0);
    chk("hold_release_after_xfer", obs_a, pk(0, 0, 0, 0, 0, 1, 2, 0));
    chk("stock_drained", dut.r_stock, 0);

    en_pulse();
    chk("disable_clears_exhausted_s10", obs_b, pk(0, 0, 0, 0, 0, 0, 2, 0));
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("ack_in_idle_ignored", obs_a, pk(0, 0, 0, 0, 0, 0, 2, 0));
    chk("ack_in_idle_stock", dut.r_stock, 60);

    // ack never arrives: disp_req must stay up exactly ACK_TIMEOUT cycles
    drain(15);
    chk("timeout_req_start", obs_a, pk(1, 0, 0, 1, 0, 0, 0, 5));
    n_req = 1;
    for (int i = 0; i < 5000 && req_a; i++) begin
      cyc(1'b0, 1'b0);
      if (req_a) n_req++;
    end
    chk("timeout_req_cycles", n_req, 4095);
    chk("fault_outputs", obs_a, pk(0, 1, 1, 1, 0, 0, 0, 5));
    cyc(1'b0, 1'b1);
    chk("fault_is_sticky", obs_a, pk(0, 1, 1, 1, 0, 0, 0, 5));
    en_pulse();

    // async reset while disp_req is high
    drain(15);
    chk("req_before_reset", req_a, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", obs_a, pk(0, 0, 0, 0, 0, 0, 2, 0));
    chk("async_reset_stock", dut.r_stock, 60);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1);
    chk("after_reset_idle", obs_a, pk(0, 0, 0, 0, 0, 0, 2, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
